sftm_dpm_credit_fifo: RTL and testbench

// Group FIFO between the SFTM (producer) and DPM (consumer), with credit-based admission of groups.
// It is the status-producing end of the global controller interface.
// It generates fifo_full, fifo_empty, fifo_count and credit_available for the controller.
// A group may start only while a credit is held; the DPM returns the credit when it retires the group.

---
 rtl/sftm_dpm_credit_fifo_if.sv | 31 +++
 rtl/sftm_dpm_credit_fifo.sv | 170 +++++++++++++++++
 tb/tb_sftm_dpm_credit_fifo.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sftm_dpm_credit_fifo_if.sv
// ----------------------------------------------------------------------------
// sftm_dpm_credit_fifo_if
// Beat-level handshake bundle between the SFTM (producer), the group FIFO and
// the DPM (consumer).
//   wr_valid / wr_last / wr_data / wr_ready : SFTM -> FIFO write channel
//   rd_valid / rd_data / rd_ready           : FIFO -> DPM read channel (FWFT)
// Modports:
//   slave  : the FIFO side (accepts writes, presents reads)
//   master : the environment side (SFTM + DPM)
// ----------------------------------------------------------------------------
interface sftm_dpm_credit_fifo_if #(
    parameter int DATA_W = 64
);
    logic              wr_valid;
    logic              wr_last;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;

    modport slave (
        input  wr_valid, wr_last, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );

    modport master (
        output wr_valid, wr_last, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/sftm_dpm_credit_fifo.sv
// ----------------------------------------------------------------------------
// sftm_dpm_credit_fifo
// Group FIFO between the SFTM and the DPM with credit-based group admission.
// A new group may only start while a credit is held; the DPM hands the credit
// back with a one-cycle dpm_retire pulse when it has retired a group.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous clear of FIFO, credits and credit_err
//   dpm_retire        DPM finished one group: return one credit
//   bus (slave)       write channel (wr_valid/wr_last/wr_data/wr_ready) and
//                     FWFT read channel (rd_valid/rd_data/rd_ready)
//   fifo_count        occupied entries, 0..FIFO_DEPTH
//   fifo_full/empty   count == FIFO_DEPTH / count == 0
//   credit_available  at least one credit held
//   hi_water/lo_water count >= 3/4 depth / count <= 1/4 depth
//   credit_err        sticky: retire received while all credits were held
// All status outputs derive from registered state only.
// ----------------------------------------------------------------------------
module sftm_dpm_credit_fifo #(
    parameter int DATA_W      = 64,
    parameter int FIFO_DEPTH  = 8,
    parameter int MAX_CREDITS = 2,
    parameter int CNT_W       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         dpm_retire,
    sftm_dpm_credit_fifo_if.slave        bus,
    output logic [CNT_W-1:0]             fifo_count,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic                         credit_available,
    output logic                         hi_water,
    output logic                         lo_water,
    output logic                         credit_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CRD_W = $clog2(MAX_CREDITS + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HI_C    = CNT_W'(3 * FIFO_DEPTH / 4);
    localparam logic [CNT_W-1:0] LO_C    = CNT_W'(FIFO_DEPTH / 4);
    localparam logic [CRD_W-1:0] MAXC_C  = CRD_W'(MAX_CREDITS);

    typedef enum logic [0:0] {
        G_IDLE = 1'b0,
        G_IN   = 1'b1
    } grp_state_e;

    grp_state_e         state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CRD_W-1:0]   credits_q, credits_d;
    logic               credit_err_q, credit_err_d;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  mem_d [FIFO_DEPTH];

    logic wr_ready_int;
    logic rd_valid_int;
    logic push;
    logic pop;
    logic grp_start;
    logic retire_ok;

    // ------------------------------------------------------------------
    // Registered-only outputs
    // ------------------------------------------------------------------
    always_comb begin
        fifo_full        = (count_q == DEPTH_C);
        fifo_empty       = (count_q == '0);
        credit_available = (credits_q != '0);
        hi_water         = (count_q >= HI_C);
        lo_water         = (count_q <= LO_C);
        fifo_count       = count_q;
        credit_err       = credit_err_q;
        // Mid-group beats never need a credit; only a group start does.
        wr_ready_int     = !fifo_full && ((state_q == G_IN) || credit_available);
        rd_valid_int     = !fifo_empty;
        bus.wr_ready     = wr_ready_int;
        bus.rd_valid     = rd_valid_int;
        bus.rd_data      = mem_q[rd_ptr_q];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        mem_d        = mem_q;

        push      = bus.wr_valid && wr_ready_int;
        pop       = rd_valid_int && bus.rd_ready;
        grp_start = push && (state_q == G_IDLE);
        // A retire while every credit is already held has nothing to return.
        retire_ok = dpm_retire && (credits_q != MAXC_C);

        if (flush) begin
            state_d      = G_IDLE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            credits_d    = MAXC_C;
            credit_err_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = bus.wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            unique case (state_q)
                G_IDLE: if (push && !bus.wr_last) state_d = G_IN;
                G_IN:   if (push &&  bus.wr_last) state_d = G_IDLE;
                default: state_d = G_IDLE;
            endcase

            unique case ({grp_start, retire_ok})
                2'b10:   credits_d = credits_q - CRD_W'(1);
                2'b01:   credits_d = credits_q + CRD_W'(1);
                default: credits_d = credits_q;
            endcase

            if (dpm_retire && !retire_ok) begin
                credit_err_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= G_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            credits_q    <= MAXC_C;
            credit_err_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
            mem_q        <= mem_d;
        end
    end

endmodule

// File: tb/tb_sftm_dpm_credit_fifo.sv
// ----------------------------------------------------------------------------
// tb_sftm_dpm_credit_fifo
// Directed bench for the SFTM->DPM credit FIFO. A queue-based model of the
// FIFO contents, credit pool and group membership predicts every output; a
// compare process checks the DUT against it on each falling edge, and the
// directed sequence adds hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_sftm_dpm_credit_fifo;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;
    localparam int MAXC   = 2;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             dpm_retire = 1'b0;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty, credit_available;
    logic             hi_water, lo_water, credit_err;

    sftm_dpm_credit_fifo_if #(.DATA_W(DATA_W)) bus ();

    sftm_dpm_credit_fifo #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (DEPTH),
        .MAX_CREDITS (MAXC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .dpm_retire       (dpm_retire),
        .bus              (bus.slave),
        .fifo_count       (fifo_count),
        .fifo_full        (fifo_full),
        .fifo_empty       (fifo_empty),
        .credit_available (credit_available),
        .hi_water         (hi_water),
        .lo_water         (lo_water),
        .credit_err       (credit_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] m_q [$];
    int                m_credits = MAXC;
    bit                m_in_grp  = 1'b0;
    bit                m_err     = 1'b0;

    function automatic bit m_wr_ready();
        return (m_q.size() < DEPTH) && (m_in_grp || m_credits > 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_credits = MAXC;
            m_in_grp  = 1'b0;
            m_err     = 1'b0;
        end else if (flush) begin
            m_q.delete();
            m_credits = MAXC;
            m_in_grp  = 1'b0;
            m_err     = 1'b0;
        end else begin
            bit push, pop, start, ret_ok;
            push   = bus.wr_valid && m_wr_ready();
            pop    = (m_q.size() > 0) && bus.rd_ready;
            start  = push && !m_in_grp;
            ret_ok = dpm_retire && (m_credits < MAXC);
            if (dpm_retire && !ret_ok) m_err = 1'b1;
            m_credits = m_credits + int'(ret_ok) - int'(start);
            if (pop)  void'(m_q.pop_front());
            if (push) begin
                m_q.push_back(bus.wr_data);
                m_in_grp = !bus.wr_last;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            int sz;
            sz = m_q.size();
            check("count",     64'(fifo_count),       64'(sz));
            check("full",      64'(fifo_full),        64'(sz == DEPTH));
            check("empty",     64'(fifo_empty),       64'(sz == 0));
            check("credit_av", 64'(credit_available), 64'(m_credits > 0));
            check("wr_ready",  64'(bus.wr_ready),     64'(m_wr_ready()));
            check("rd_valid",  64'(bus.rd_valid),     64'(sz > 0));
            check("hi_water",  64'(hi_water),         64'(sz >= 3 * DEPTH / 4));
            check("lo_water",  64'(lo_water),         64'(sz <= DEPTH / 4));
            check("credit_err",64'(credit_err),       64'(m_err));
            if (sz > 0) check("rd_data", bus.rd_data, m_q[0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_beat(input logic [63:0] d, input logic last);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_last  = last;
        cycle();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic pop_n(input int n);
        bus.rd_ready = 1'b1;
        repeat (n) cycle();
        bus.rd_ready = 1'b0;
    endtask

    task automatic retire();
        dpm_retire = 1'b1;
        cycle();
        dpm_retire = 1'b0;
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("rst_empty",  64'(fifo_empty), 64'd1);
        check("rst_count",  64'(fifo_count), 64'd0);
        check("rst_credit", 64'(credit_available), 64'd1);
        check("rst_wr_rdy", 64'(bus.wr_ready), 64'd1);
        check("rst_err",    64'(credit_err), 64'd0);
        check("rst_rd_data",bus.rd_data, 64'd0);
        check("rst_lo",     64'(lo_water), 64'd1);

        // One 8-beat group, no pops
        for (int i = 0; i < 8; i++) begin
            push_beat(64'(100 + i), (i == 7));
            if (i == 0) check("g8_credit_after_b1", 64'(credit_available), 64'd1);
            if (i == 4) check("g8_hi_at5", 64'(hi_water), 64'd0);
            if (i == 5) check("g8_hi_at6", 64'(hi_water), 64'd1);
        end
        check("g8_full",     64'(fifo_full), 64'd1);
        check("g8_wr_ready", 64'(bus.wr_ready), 64'd0);
        check("g8_count",    64'(fifo_count), 64'd8);
        bus.wr_valid = 1'b1; bus.wr_data = 64'd999; bus.wr_last = 1'b1;
        cycle();
        check("g8_9th_held", 64'(fifo_count), 64'd8);
        bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
        check("g8_head", bus.rd_data, 64'd100);
        pop_n(8);
        check("g8_drained", 64'(fifo_empty), 64'd1);
        retire();

        // Two single-beat groups exhaust credits
        push_beat(64'd1, 1'b1);
        push_beat(64'd2, 1'b1);
        check("cr_none",     64'(credit_available), 64'd0);
        check("cr_wr_stall", 64'(bus.wr_ready), 64'd0);
        bus.wr_valid = 1'b1; bus.wr_data = 64'd3; bus.wr_last = 1'b1;
        cycle();
        check("cr_third_held", 64'(fifo_count), 64'd2);
        dpm_retire = 1'b1;
        cycle();
        dpm_retire = 1'b0;
        check("cr_back",      64'(credit_available), 64'd1);
        check("cr_wr_ready",  64'(bus.wr_ready), 64'd1);
        cycle();
        bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
        check("cr_third_in",  64'(fifo_count), 64'd3);
        pop_n(3);
        retire();
        retire();
        check("cr_no_err", 64'(credit_err), 64'd0);

        // Streaming: 20 values, count held at 4 through pointer wrap
        for (int i = 0; i < 4; i++) push_beat(64'(200 + i), 1'b0);
        check("st_head0", bus.rd_data, 64'd200);
        bus.rd_ready = 1'b1;
        for (int i = 4; i < 20; i++) begin
            bus.wr_valid = 1'b1; bus.wr_data = 64'(200 + i); bus.wr_last = (i == 19);
            cycle();
            check("st_count4", 64'(fifo_count), 64'd4);
            check("st_head",   bus.rd_data, 64'(200 + i - 3));
        end
        bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
        repeat (4) cycle();
        bus.rd_ready = 1'b0;
        check("st_empty", 64'(fifo_empty), 64'd1);
        retire();

        // Retire with all credits held
        retire();
        check("err_set", 64'(credit_err), 64'd1);
        cycle();
        check("err_sticky", 64'(credit_err), 64'd1);
        push_beat(64'd7, 1'b1);
        push_beat(64'd8, 1'b1);
        check("err_credits_stayed2", 64'(credit_available), 64'd0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("err_flushed",  64'(credit_err), 64'd0);
        check("err_fl_count", 64'(fifo_count), 64'd0);

        // Flush mid-group at count 5, with push/pop/retire all asserted
        for (int i = 0; i < 5; i++) push_beat(64'(300 + i), 1'b0);
        check("fl_count5", 64'(fifo_count), 64'd5);
        flush = 1'b1; dpm_retire = 1'b1; bus.rd_ready = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_data = 64'd333; bus.wr_last = 1'b0;
        cycle();
        flush = 1'b0; dpm_retire = 1'b0; bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b0;
        check("fl_count0", 64'(fifo_count), 64'd0);
        check("fl_empty",  64'(fifo_empty), 64'd1);
        check("fl_credit", 64'(credit_available), 64'd1);
        check("fl_no_err", 64'(credit_err), 64'd0);
        push_beat(64'd55, 1'b1);
        check("fl_new_grp", 64'(fifo_count), 64'd1);
        check("fl_new_data", bus.rd_data, 64'd55);

        // Asynchronous reset mid-group
        push_beat(64'd60, 1'b0);
        push_beat(64'd61, 1'b0);
        rst_n = 1'b0;
        #1;
        check("ar_count",    64'(fifo_count), 64'd0);
        check("ar_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("ar_credit",   64'(credit_available), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        push_beat(64'd70, 1'b1);
        check("ar_after", 64'(fifo_count), 64'd1);
        check("ar_data",  bus.rd_data, 64'd70);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
